// File: rtl/fft_pkg.sv
// Shared FFT definitions: loader state encoding, default geometry and the
// Q1.15 coefficient type used by the twiddle table.
package fft_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic signed [WIDTH_DEF-1:0] q15_t;

endpackage

// File: rtl/twiddle_loader_if.sv
// Coefficient-pair stream from a twiddle source into the loader.
interface twiddle_loader_if
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_wr;
    logic signed [WIDTH-1:0] s_wi;
    logic                    s_last;

    modport master (output s_valid, s_wr, s_wi, s_last, input s_ready);
    modport slave  (input s_valid, s_wr, s_wi, s_last, output s_ready);

endinterface

// File: rtl/twiddle_dpram.sv
// Simple dual-port coefficient store: one write port, one registered read port
// with read-old-data behaviour on a same-address collision.
module twiddle_dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Output register; nonblocking read sees the pre-write word on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/twiddle_loader.sv
// Loads a count-terminated stream of twiddle pairs into a dual-port table and
// serves registered FFT-side reads; reports completion and framing errors.
module twiddle_loader
    import fft_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     n_entries,
    twiddle_loader_if.slave         src,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic signed [WIDTH-1:0] rd_wr,
    output logic signed [WIDTH-1:0] rd_wi,
    output logic                    busy,
    output logic                    done,
    output logic                    table_valid,
    output logic                    err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    function automatic logic count_legal(input logic [ADDR_WIDTH:0] n);
        return (n != '0) && (n <= DEPTH_C);
    endfunction

    state_e                  state_r, state_nxt_s;
    logic [ADDR_WIDTH:0]     n_r, n_nxt_s;
    logic [ADDR_WIDTH:0]     wr_ptr_r, wr_ptr_nxt_s;
    logic                    err_r, err_nxt_s;
    logic                    tv_r, tv_nxt_s;
    logic                    s_ready_r, busy_r, done_r;
    logic                    hs_s, final_hs_s, we_s;
    logic [2*WIDTH-1:0]      rdata_s;

    assign hs_s       = src.s_valid && s_ready_r;
    assign final_hs_s = (wr_ptr_r == (n_r - ONE_C));

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            n_r       <= '0;
            wr_ptr_r  <= '0;
            err_r     <= 1'b0;
            tv_r      <= 1'b0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            n_r       <= n_nxt_s;
            wr_ptr_r  <= wr_ptr_nxt_s;
            err_r     <= err_nxt_s;
            tv_r      <= tv_nxt_s;
            s_ready_r <= (state_nxt_s == LOAD);
            busy_r    <= (state_nxt_s == LOAD);
            done_r    <= (state_nxt_s == DONE);
        end
    end

    // Next-state, write strobe and error tracking.
    always_comb begin
        state_nxt_s  = state_r;
        n_nxt_s      = n_r;
        wr_ptr_nxt_s = wr_ptr_r;
        err_nxt_s    = err_r;
        tv_nxt_s     = tv_r;
        we_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && count_legal(n_entries)) begin
                    n_nxt_s      = n_entries;
                    wr_ptr_nxt_s = '0;
                    err_nxt_s    = 1'b0;
                    tv_nxt_s     = 1'b0;
                    state_nxt_s  = LOAD;
                end else if (start) begin
                    err_nxt_s = 1'b1;
                    tv_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (hs_s) begin
                    we_s         = 1'b1;
                    wr_ptr_nxt_s = wr_ptr_r + ONE_C;
                    // s_last is only a framing check; the count alone ends the load.
                    if (final_hs_s) begin
                        state_nxt_s = DONE;
                        err_nxt_s   = err_r | ~src.s_last;
                    end else begin
                        err_nxt_s   = err_r | src.s_last;
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            DONE: begin
                tv_nxt_s    = ~err_r;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    twiddle_dpram #(
        .DATA_WIDTH (2*WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dpram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wdata ({src.s_wr, src.s_wi}),
        .raddr (rd_addr),
        .rdata (rdata_s)
    );

    assign src.s_ready = s_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign table_valid = tv_r;
    assign err         = err_r;
    assign rd_wr       = rdata_s[2*WIDTH-1:WIDTH];
    assign rd_wi       = rdata_s[WIDTH-1:0];

endmodule

// File: tb/tb_twiddle_loader.sv
// Directed, table-driven bench for twiddle_loader: full, backpressured,
// mis-framed, rejected and reset-aborted loads plus read-during-write.
module tb_twiddle_loader;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [9:0]        n_entries = 10'd0;
    logic [8:0]        rd_addr = 9'd0;
    logic signed [15:0] rd_wr, rd_wi;
    logic              busy, done, table_valid, err;

    int vectors = 0;
    int fails   = 0;

    twiddle_loader_if #(.WIDTH(16)) bus ();

    twiddle_loader #(.WIDTH(16), .ADDR_WIDTH(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_entries   (n_entries),
        .src         (bus),
        .rd_addr     (rd_addr),
        .rd_wr       (rd_wr),
        .rd_wi       (rd_wi),
        .busy        (busy),
        .done        (done),
        .table_valid (table_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] wr;
        logic [15:0] wi;
    } rd_vec_t;

    typedef struct {
        int   n;
        logic exp_err;
        logic exp_busy;
        logic exp_tv;
    } bad_vec_t;

    rd_vec_t  full_tbl [6];
    bad_vec_t bad_tbl  [2];

    // Seed 0 is the real twiddle pattern at k=0,128,511 with filler elsewhere.
    function automatic logic [31:0] dat(input int k, input int seed);
        logic [11:0] kk;
        logic [3:0]  ss;
        logic [15:0] w;
        kk = k[11:0];
        ss = seed[3:0];
        if (seed != 0) begin
            w = {ss, kk};
            return {w, ~w};
        end
        if (k == 0)   return {16'h7FFF, 16'h0000};
        if (k == 128) return {16'h5A82, 16'hA57E};
        if (k == 511) return {16'h8001, 16'hFF37};
        w = k[15:0] * 16'd37;
        return {w ^ 16'hA5A5, ~(k[15:0] * 16'd11)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input int addr, input logic [31:0] exp);
        rd_addr = addr[8:0];
        @(posedge clk); #1;
        check($sformatf("rd_wr[%0d]", addr), {16'h0, rd_wr}, {16'h0, exp[31:16]});
        check($sformatf("rd_wi[%0d]", addr), {16'h0, rd_wi}, {16'h0, exp[15:0]});
    endtask

    task automatic load(input int n, input bit rnd, input int last_idx, input int seed,
                        input bit poke_start, input bit exp_err);
        int sent  = 0;
        int cyc   = 0;
        int dones = 0;
        bit hs;
        logic [31:0] d;
        start = 1'b1;
        n_entries = n[9:0];
        @(posedge clk); #1;
        start = 1'b0;
        n_entries = 10'd0;
        while (sent < n && cyc < 4*n + 50) begin
            bus.s_valid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            d = dat(sent, seed);
            bus.s_wr   = d[31:16];
            bus.s_wi   = d[15:0];
            bus.s_last = (sent == last_idx);
            if (poke_start && cyc == 3) begin
                start = 1'b1;
            end
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dones++;
            if (hs) begin
                sent++;
                if (sent == n) check("done_after_last", {31'd0, done}, 32'd1);
            end
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("load_count", sent, n);
        @(posedge clk); #1;
        if (done) dones++;
        check("busy_after", {31'd0, busy}, 32'd0);
        check("ready_after", {31'd0, bus.s_ready}, 32'd0);
        check("table_valid", {31'd0, table_valid}, {31'd0, ~exp_err});
        check("err", {31'd0, err}, {31'd0, exp_err});
        @(posedge clk); #1;
        if (done) dones++;
        check("done_once", dones, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        full_tbl[0] = '{0,   16'h7FFF, 16'h0000};
        full_tbl[1] = '{128, 16'h5A82, 16'hA57E};
        full_tbl[2] = '{511, 16'h8001, 16'hFF37};
        full_tbl[3] = '{1,   16'hA580, 16'hFFF4};
        full_tbl[4] = '{255, 16'h817E, 16'hF50A};
        full_tbl[5] = '{256, 16'h80A5, 16'hF4FF};
        bad_tbl[0]  = '{0,   1'b1, 1'b0, 1'b0};
        bad_tbl[1]  = '{513, 1'b1, 1'b0, 1'b0};

        bus.s_valid = 1'b0;
        bus.s_wr    = 16'd0;
        bus.s_wi    = 16'd0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tv", {31'd0, table_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rd", {rd_wr, rd_wi}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full continuous load and table read-back.
        load(512, 1'b0, 511, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rd_chk(full_tbl[i].addr, {full_tbl[i].wr, full_tbl[i].wi});
        end

        // Rejected starts, each preceded by a good single-entry load to clear err.
        for (int i = 0; i < 2; i++) begin
            load(1, 1'b0, 0, 3, 1'b0, 1'b0);
            start = 1'b1;
            n_entries = bad_tbl[i].n[9:0];
            @(posedge clk); #1;
            start = 1'b0;
            check("bad_err", {31'd0, err}, {31'd0, bad_tbl[i].exp_err});
            check("bad_busy", {31'd0, busy}, {31'd0, bad_tbl[i].exp_busy});
            check("bad_tv", {31'd0, table_valid}, {31'd0, bad_tbl[i].exp_tv});
            @(posedge clk); #1;
            check("bad_busy2", {31'd0, busy}, 32'd0);
        end

        // Backpressure with an ignored start mid-load; entry 8 must be untouched.
        load(8, 1'b1, 7, 4, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) rd_chk(k, dat(k, 4));
        rd_chk(8, dat(8, 0));

        // Early s_last, then missing s_last.
        load(4, 1'b0, 1, 5, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) rd_chk(k, dat(k, 5));
        load(4, 1'b0, -1, 6, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) rd_chk(k, dat(k, 6));

        // Read-during-write on the write address.
        start = 1'b1;
        n_entries = 10'd2;
        @(posedge clk); #1;
        start = 1'b0;
        rd_addr = 9'd0;
        bus.s_valid = 1'b1;
        {bus.s_wr, bus.s_wi} = dat(0, 7);
        @(posedge clk); #1;
        check("rdw_old0", {rd_wr, rd_wi}, dat(0, 6));
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        check("rdw_new0", {rd_wr, rd_wi}, dat(0, 7));
        rd_addr = 9'd1;
        bus.s_valid = 1'b1;
        bus.s_last = 1'b1;
        {bus.s_wr, bus.s_wi} = dat(1, 7);
        @(posedge clk); #1;
        check("rdw_old1", {rd_wr, rd_wi}, dat(1, 6));
        check("rdw_done", {31'd0, done}, 32'd1);
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        @(posedge clk); #1;
        check("rdw_new1", {rd_wr, rd_wi}, dat(1, 7));
        check("rdw_tv", {31'd0, table_valid}, 32'd1);

        // Reset after 100 of 512 pairs, then a clean reload.
        rd_addr = 9'd128;
        start = 1'b1;
        n_entries = 10'd512;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            bus.s_valid = 1'b1;
            {bus.s_wr, bus.s_wi} = dat(k, 8);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_ready", {31'd0, bus.s_ready}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_tv", {31'd0, table_valid}, 32'd0);
        check("mid_err", {31'd0, err}, 32'd0);
        check("mid_rd", {rd_wr, rd_wi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tv", {31'd0, table_valid}, 32'd0);
        load(512, 1'b0, 511, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rd_chk(full_tbl[i].addr, {full_tbl[i].wr, full_tbl[i].wi});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/twiddle_loader.md
TWIDDLE_LOADER -- requirements
Module: twiddle_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning Q1.15 coefficient width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning table depth of 2^ADDR_WIDTH entries (512, for the N/2 twiddles of a 1024-point FFT).
REQ-003 clk  input  1  sole clock; all state is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle load request.
REQ-006 n_entries  input  ADDR_WIDTH+1  number of entries to load; sampled when start is accepted.
REQ-007 s_valid  input  1  source has a coefficient pair.
REQ-008 s_ready  output  1  loader accepts a pair.
REQ-009 s_wr, s_wi  input  WIDTH each  signed cos and -sin samples.
REQ-010 s_last  input  1  source marks the final pair.
REQ-011 rd_addr  input  ADDR_WIDTH  FFT-side read index k.
REQ-012 rd_wr, rd_wi  output  WIDTH each  signed registered read data.
REQ-013 busy  output  1  a load is in progress.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 table_valid  output  1  the table holds a complete, error-free load.
REQ-016 err  output  1  sticky error flag for the last load request.

Function
REQ-017 SHALL implement three states:
- IDLE: s_ready=0, busy=0.
- LOAD: s_ready=1, busy=1.
- DONE: lasts one cycle, done=1; then returns to IDLE.
REQ-018 In IDLE, start with 1 <= n_entries <= 2^ADDR_WIDTH SHALL:
- capture n_entries;
- clear wr_ptr, err and table_valid;
- enter LOAD on the next cycle.
REQ-019 In IDLE, start with n_entries=0 or n_entries > 2^ADDR_WIDTH SHALL set err=1, clear table_valid, and remain in IDLE.
REQ-020 start SHALL be ignored in LOAD and DONE.
REQ-021 A handshake (s_valid && s_ready) SHALL write s_wr/s_wi to entry wr_ptr and increment wr_ptr; no write occurs without a handshake.
REQ-022 The handshake that writes entry n_entries-1 SHALL move the state to DONE. Termination is by count only; s_last never terminates a load.
REQ-023 s_last=1 on any earlier handshake, or s_last=0 on the final handshake, SHALL set err=1. The load SHALL still run to count.
REQ-024 In DONE, table_valid SHALL become 1 if err=0; done SHALL pulse regardless of err.
REQ-025 Read path SHALL have 1-cycle latency: rd_wr/rd_wi at cycle t+1 reflect rd_addr at cycle t. Reads are legal in every state.
REQ-026 A read and write of the same address in the same cycle SHALL return the old data.
REQ-027 s_wr/s_wi SHALL be stored bit-exact, with no saturation or rounding.
REQ-028 wr_ptr SHALL be ADDR_WIDTH+1 bits wide so a full 2^ADDR_WIDTH load does not wrap before completion.

Reset
REQ-029 Reset SHALL force: state IDLE, s_ready=0, busy=0, done=0, table_valid=0, err=0, wr_ptr=0, rd_wr=0, rd_wi=0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted mid-LOAD SHALL abort the load; table_valid stays 0 until a later complete load.

Structure
REQ-032 A shared package fft_pkg SHALL hold:
- the state enum (IDLE, LOAD, DONE);
- the WIDTH and ADDR_WIDTH defaults;
- a Q1.15 coefficient typedef.
REQ-033 Storage SHALL be a sub-module twiddle_dpram: simple dual-port, one write port, one registered read port, inferable as block RAM.
REQ-034 The FSM, counter and error logic SHALL stay in twiddle_loader.

Verification
REQ-035 Full load: start, n_entries=512, 512 continuous pairs with s_last on the 512th.
- Response: done pulses one cycle after the last handshake; table_valid=1, err=0.
- Reading k=0,128,511 returns 0x7FFF/0x0000, 0x5A82/0xA57E, the loaded values.
REQ-036 Backpressure: s_valid toggled randomly, n_entries=8.
- Response: exactly 8 writes, in order; done once; no write while s_valid=0.
REQ-037 Bad last, n_entries=4:
- s_last on pair 2 -> all 4 pairs still written, err=1, table_valid=0.
- s_last absent on pair 4 -> err=1, table_valid=0.
REQ-038 Bad start:
- n_entries=0 -> err=1 next cycle, busy stays 0.
- n_entries=513 -> same response.
REQ-039 Reset mid-load: rst_n low after 100 of 512 pairs.
- Response: all outputs at reset values immediately; table_valid=0.
- A new 512-entry load then completes normally.
REQ-040 Read-during-write: rd_addr equals wr_ptr on the write cycle.
- Response: old value next cycle; new value one cycle later.
